// File: rtl/bus_arbiter_if.sv
// Bundle of the two master request ports plus the single shared bus port
// seen by bus_arbiter. The "slave" modport is the arbiter's view (it serves
// both masters and drives the bus). The "master" modport is the surrounding
// system's view: the two masters and the bus read-data source.
interface bus_arbiter_if;
    // master 0 (CPU MEM stage)
    logic        req0;
    logic        MemRead0;
    logic        MemWrite0;
    logic [31:0] address0;
    logic [31:0] write_data0;
    logic [31:0] read_data0;
    logic        ready0;
    logic        stall0;
    logic        gnt0;

    // master 1 (DMA / loader)
    logic        req1;
    logic        MemRead1;
    logic        MemWrite1;
    logic [31:0] address1;
    logic [31:0] write_data1;
    logic [31:0] read_data1;
    logic        ready1;
    logic        stall1;
    logic        gnt1;

    // single-master bus side
    logic        bus_MemRead;
    logic        bus_MemWrite;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;

    modport slave (
        input  req0, MemRead0, MemWrite0, address0, write_data0,
        input  req1, MemRead1, MemWrite1, address1, write_data1,
        input  bus_read_data,
        output read_data0, ready0, stall0, gnt0,
        output read_data1, ready1, stall1, gnt1,
        output bus_MemRead, bus_MemWrite, bus_address, bus_write_data
    );

    modport master (
        output req0, MemRead0, MemWrite0, address0, write_data0,
        output req1, MemRead1, MemWrite1, address1, write_data1,
        output bus_read_data,
        input  read_data0, ready0, stall0, gnt0,
        input  read_data1, ready1, stall1, gnt1,
        input  bus_MemRead, bus_MemWrite, bus_address, bus_write_data
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of the memory-mapped
// bus. Grants are registered (request in cycle N -> grant in N+1); the bus
// side is a combinational mux of the owner's signals, active only while the
// owner still requests (a "beat"). Switching owners never inserts an idle
// bubble.
//
// Optional feature, macro BUS_ARB_BURST_LIMIT_EN:
//   defined   - an owner is pre-empted after MAX_BURST consecutive granted
//               cycles if the other master is requesting.
//   undefined - an owner keeps the grant while its req stays high; the burst
//               counter is not built.
module bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    // MAX_BURST must fit the saturating counter and be at least one cycle.
    if ((MAX_BURST < 32'sd1) || (MAX_BURST > ((32'sd1 <<< CNT_WIDTH) - 32'sd1))) begin : g_bad_max_burst
        $error("bus_arbiter: MAX_BURST out of range for CNT_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state_r;
    logic   gnt0_r;
    logic   gnt1_r;
    logic   rr_ptr_r;    // 0: master 0 wins a tie from IDLE, 1: master 1 wins
    logic   hold_s;      // current owner keeps the bus at this edge
    logic   preempt_s;   // owner has used up its burst allowance
    logic   beat0_s;
    logic   beat1_s;

`ifdef BUS_ARB_BURST_LIMIT_EN
    localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(MAX_BURST - 32'sd1);

    logic [CNT_WIDTH-1:0] burst_cnt_r;

    // Saturating count of extra cycles the current owner has held the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_r <= '0;
        end else if (hold_s) begin
            if (burst_cnt_r != BURST_LAST) begin
                burst_cnt_r <= burst_cnt_r + CNT_WIDTH'(1);
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
        end else begin
            burst_cnt_r <= '0;
        end
    end

    assign preempt_s = (burst_cnt_r == BURST_LAST);
`else
    assign preempt_s = 1'b0;
`endif

    // Decide whether the current owner keeps the grant across this edge.
    always_comb begin
        hold_s = 1'b0;
        case (state_r)
            OWN0:    hold_s = bus.req0 & ~(bus.req1 & preempt_s);
            OWN1:    hold_s = bus.req1 & ~(bus.req0 & preempt_s);
            default: hold_s = 1'b0;
        endcase
    end

    // Ownership FSM with registered grants and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            rr_ptr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req0 && (!bus.req1 || !rr_ptr_r)) begin
                        state_r  <= OWN0;
                        gnt0_r   <= 1'b1;
                        gnt1_r   <= 1'b0;
                        rr_ptr_r <= 1'b1;
                    end else if (bus.req1) begin
                        state_r  <= OWN1;
                        gnt0_r   <= 1'b0;
                        gnt1_r   <= 1'b1;
                        rr_ptr_r <= 1'b0;
                    end else begin
                        state_r  <= IDLE;
                        gnt0_r   <= 1'b0;
                        gnt1_r   <= 1'b0;
                    end
                end
                OWN0: begin
                    if (hold_s) begin
                        state_r <= OWN0;
                    end else if (bus.req1) begin
                        state_r  <= OWN1;
                        gnt0_r   <= 1'b0;
                        gnt1_r   <= 1'b1;
                        rr_ptr_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (hold_s) begin
                        state_r <= OWN1;
                    end else if (bus.req0) begin
                        state_r  <= OWN0;
                        gnt0_r   <= 1'b1;
                        gnt1_r   <= 1'b0;
                        rr_ptr_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                end
            endcase
        end
    end

    // A beat is a granted cycle in which the owner still requests; reset
    // suppresses it so no strobe reaches the bus in a reset cycle.
    assign beat0_s = gnt0_r & bus.req0 & ~reset;
    assign beat1_s = gnt1_r & bus.req1 & ~reset;

    assign bus.gnt0   = gnt0_r;
    assign bus.gnt1   = gnt1_r;
    assign bus.ready0 = beat0_s;
    assign bus.ready1 = beat1_s;
    assign bus.stall0 = bus.req0 & ~gnt0_r & ~reset;
    assign bus.stall1 = bus.req1 & ~gnt1_r & ~reset;

    // Forward the beat owner's access to the bus; all zero otherwise.
    always_comb begin
        bus.bus_MemRead    = 1'b0;
        bus.bus_MemWrite   = 1'b0;
        bus.bus_address    = 32'h0000_0000;
        bus.bus_write_data = 32'h0000_0000;
        if (beat0_s) begin
            bus.bus_MemRead    = bus.MemRead0;
            bus.bus_MemWrite   = bus.MemWrite0;
            bus.bus_address    = bus.address0;
            bus.bus_write_data = bus.write_data0;
        end else if (beat1_s) begin
            bus.bus_MemRead    = bus.MemRead1;
            bus.bus_MemWrite   = bus.MemWrite1;
            bus.bus_address    = bus.address1;
            bus.bus_write_data = bus.write_data1;
        end else begin
            bus.bus_MemRead    = 1'b0;
            bus.bus_MemWrite   = 1'b0;
            bus.bus_address    = 32'h0000_0000;
            bus.bus_write_data = 32'h0000_0000;
        end
    end

    // Return read data only to the master whose beat is active.
    always_comb begin
        bus.read_data0 = 32'h0000_0000;
        bus.read_data1 = 32'h0000_0000;
        if (beat0_s) begin
            bus.read_data0 = bus.bus_read_data;
        end else if (beat1_s) begin
            bus.read_data1 = bus.bus_read_data;
        end else begin
            bus.read_data0 = 32'h0000_0000;
            bus.read_data1 = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// ownership model (owner index, preferred master, cycles owned so far).
module tb_bus_arbiter;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if bif();

    bus_arbiter #(.MAX_BURST(MAXB), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int   checks   = 0;
    int   failures = 0;
    logic check_en = 1'b0;

    // Reference model: -1 none, 0 or 1 = owning master.
    int m_owner  = -1;
    int m_prefer = 0;
    int m_run    = 0;   // cycles the owner has held the bus, including now

    logic exp_gnt0, exp_gnt1, exp_beat0, exp_beat1;
    assign exp_gnt0  = (m_owner == 0);
    assign exp_gnt1  = (m_owner == 1);
    assign exp_beat0 = exp_gnt0 && bif.req0 && !reset;
    assign exp_beat1 = exp_gnt1 && bif.req1 && !reset;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on each edge from the inputs seen at that edge.
    always @(posedge clk) begin
        int  nxt;
        int  run_n;
        int  pref_n;
        logic own_req, oth_req;
        if (reset) begin
            m_owner  <= -1;
            m_prefer <= 0;
            m_run    <= 0;
        end else begin
            if (m_owner < 0) begin
                if (bif.req0 && bif.req1) nxt = m_prefer;
                else if (bif.req0)        nxt = 0;
                else if (bif.req1)        nxt = 1;
                else                      nxt = -1;
            end else begin
                own_req = (m_owner == 0) ? bif.req0 : bif.req1;
                oth_req = (m_owner == 0) ? bif.req1 : bif.req0;
                if (own_req) begin
                    nxt = m_owner;
`ifdef BUS_ARB_BURST_LIMIT_EN
                    if (oth_req && (m_run >= MAXB)) nxt = 1 - m_owner;
`endif
                end else begin
                    nxt = oth_req ? (1 - m_owner) : -1;
                end
            end
            pref_n = m_prefer;
            if (nxt < 0)             run_n = 0;
            else if (nxt == m_owner) run_n = m_run + 1;
            else begin
                run_n  = 1;
                pref_n = 1 - nxt;
            end
            m_owner  <= nxt;
            m_run    <= run_n;
            m_prefer <= pref_n;
        end
        check_en <= 1'b1;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk1("gnt0", bif.gnt0, exp_gnt0);
            chk1("gnt1", bif.gnt1, exp_gnt1);
            chk1("mutex", bif.gnt0 & bif.gnt1, 1'b0);
            chk1("ready0", bif.ready0, exp_beat0);
            chk1("ready1", bif.ready1, exp_beat1);
            chk1("stall0", bif.stall0, bif.req0 && !exp_gnt0 && !reset);
            chk1("stall1", bif.stall1, bif.req1 && !exp_gnt1 && !reset);
            chk1("bus_MemRead", bif.bus_MemRead,
                 exp_beat0 ? bif.MemRead0 : (exp_beat1 ? bif.MemRead1 : 1'b0));
            chk1("bus_MemWrite", bif.bus_MemWrite,
                 exp_beat0 ? bif.MemWrite0 : (exp_beat1 ? bif.MemWrite1 : 1'b0));
            chk32("bus_address", bif.bus_address,
                  exp_beat0 ? bif.address0 : (exp_beat1 ? bif.address1 : 32'h0));
            chk32("bus_write_data", bif.bus_write_data,
                  exp_beat0 ? bif.write_data0 : (exp_beat1 ? bif.write_data1 : 32'h0));
            chk32("read_data0", bif.read_data0, exp_beat0 ? bif.bus_read_data : 32'h0);
            chk32("read_data1", bif.read_data1, exp_beat1 ? bif.bus_read_data : 32'h0);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        bif.req0 = 1'b0; bif.MemRead0 = 1'b0; bif.MemWrite0 = 1'b0;
        bif.address0 = 32'h0; bif.write_data0 = 32'h0;
        bif.req1 = 1'b0; bif.MemRead1 = 1'b0; bif.MemWrite1 = 1'b0;
        bif.address1 = 32'h0; bif.write_data1 = 32'h0;
    endtask

    initial begin
        int first_gnt1, rdy0_before, gnt0_cnt, stall1_cnt;
        logic pend0, pend1, served0, served1;

        reset = 1'b1;
        clear_masters();
        bif.bus_read_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("idle_gnt0", bif.gnt0, 1'b0);
            chk1("idle_gnt1", bif.gnt1, 1'b0);
            chk1("idle_wr", bif.bus_MemWrite, 1'b0);
            chk32("idle_addr", bif.bus_address, 32'h0);
            next();
        end

        // single write from master 0
        bif.req0 = 1'b1; bif.MemWrite0 = 1'b1;
        bif.address0 = 32'h0000_0010; bif.write_data0 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("wr_stallN", bif.stall0, 1'b1);
        chk1("wr_gntN", bif.gnt0, 1'b0);
        chk1("wr_busN", bif.bus_MemWrite, 1'b0);
        next();
        @(negedge clk);
        chk1("wr_gnt", bif.gnt0, 1'b1);
        chk1("wr_strobe", bif.bus_MemWrite, 1'b1);
        chk32("wr_addr", bif.bus_address, 32'h0000_0010);
        chk32("wr_data", bif.bus_write_data, 32'hDEAD_BEEF);
        chk1("wr_ready", bif.ready0, 1'b1);
        chk1("wr_stall", bif.stall0, 1'b0);
        next();
        clear_masters();
        @(negedge clk);
        chk1("drop_gnt", bif.gnt0, 1'b1);
        chk1("drop_wr", bif.bus_MemWrite, 1'b0);
        chk1("drop_ready", bif.ready0, 1'b0);
        next();
        @(negedge clk);
        chk1("drop_idle", bif.gnt0, 1'b0);
        next();

        // round robin with no bubble
        reset = 1'b1; next(); reset = 1'b0;
        bif.req0 = 1'b1; bif.MemRead0 = 1'b1; bif.address0 = 32'h20;
        bif.req1 = 1'b1; bif.MemRead1 = 1'b1; bif.address1 = 32'h30;
        @(negedge clk);
        chk1("rr_stall0", bif.stall0, 1'b1);
        chk1("rr_stall1", bif.stall1, 1'b1);
        next();
        @(negedge clk);
        chk1("rr_first0", bif.gnt0, 1'b1);
        chk1("rr_first1", bif.gnt1, 1'b0);
        chk32("rr_addr0", bif.bus_address, 32'h20);
        next();
        bif.req0 = 1'b0; bif.MemRead0 = 1'b0;
        @(negedge clk);
        chk1("rr_hold_gnt0", bif.gnt0, 1'b1);
        chk1("rr_hold_stall1", bif.stall1, 1'b1);
        next();
        @(negedge clk);
        chk1("rr_sw_gnt1", bif.gnt1, 1'b1);
        chk1("rr_sw_gnt0", bif.gnt0, 1'b0);
        chk1("rr_sw_ready1", bif.ready1, 1'b1);
        chk32("rr_addr1", bif.bus_address, 32'h30);
        next();
        bif.req1 = 1'b0; bif.MemRead1 = 1'b0;
        @(negedge clk);
        next();
        bif.req0 = 1'b1; bif.MemRead0 = 1'b1;
        bif.req1 = 1'b1; bif.MemRead1 = 1'b1;
        @(negedge clk);
        chk1("rr_idle_gnt0", bif.gnt0, 1'b0);
        chk1("rr_idle_gnt1", bif.gnt1, 1'b0);
        next();
        @(negedge clk);
        chk1("rr_again_gnt0", bif.gnt0, 1'b1);
        chk1("rr_again_gnt1", bif.gnt1, 1'b0);
        next();
        clear_masters();
        next();

        // burst behaviour with req0 held and req1 raised one cycle after OWN0
        reset = 1'b1; next(); reset = 1'b0;
        bif.req0 = 1'b1; bif.MemWrite0 = 1'b1; bif.address0 = 32'h100;
        next();
        first_gnt1 = -1; rdy0_before = 0; gnt0_cnt = 0; stall1_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bif.write_data0 = 32'(i);
            if (i == 1) begin
                bif.req1 = 1'b1; bif.MemWrite1 = 1'b1; bif.address1 = 32'h200;
            end
            @(negedge clk);
            if (bif.gnt1 && first_gnt1 < 0) first_gnt1 = i;
            if (first_gnt1 < 0 && bif.ready0) rdy0_before++;
            if (bif.gnt0) gnt0_cnt++;
            if (bif.stall1) stall1_cnt++;
            next();
        end
`ifdef BUS_ARB_BURST_LIMIT_EN
        chk32("burst_switch_cycle", 32'(first_gnt1), 32'd8);
        chk32("burst_ready0_pulses", 32'(rdy0_before), 32'd8);
`else
        chk32("noburst_gnt0_cycles", 32'(gnt0_cnt), 32'd20);
        chk32("noburst_stall1_cycles", 32'(stall1_cnt), 32'd19);
        chk32("noburst_no_gnt1", 32'(first_gnt1), 32'hFFFF_FFFF);
`endif
        clear_masters();
        next();
        next();

        // master 1 read, then reset mid-OWN1
        reset = 1'b1; next(); reset = 1'b0;
        bif.req1 = 1'b1; bif.MemRead1 = 1'b1; bif.address1 = 32'h4000_000C;
        bif.bus_read_data = 32'h0000_00A5;
        @(negedge clk);
        next();
        @(negedge clk);
        chk1("rd_gnt1", bif.gnt1, 1'b1);
        chk32("rd_data1", bif.read_data1, 32'h0000_00A5);
        chk32("rd_data0", bif.read_data0, 32'h0);
        chk1("rd_strobe", bif.bus_MemRead, 1'b1);
        chk32("rd_addr", bif.bus_address, 32'h4000_000C);
        next();
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_no_strobe", bif.bus_MemRead, 1'b0);
        chk1("rst_no_ready", bif.ready1, 1'b0);
        chk32("rst_no_rdata", bif.read_data1, 32'h0);
        next();
        reset = 1'b0;
        clear_masters();
        @(negedge clk);
        chk1("rst_gnt1", bif.gnt1, 1'b0);
        next();

        // randomized traffic; a master holds its request until served
        pend0 = 1'b0; pend1 = 1'b0; served0 = 1'b1; served1 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!pend0 || served0) begin
                pend0 = ($urandom_range(0, 99) < 55);
                bif.MemRead0  = ($urandom_range(0, 2) == 0);
                bif.MemWrite0 = !bif.MemRead0 && ($urandom_range(0, 1) == 1);
                bif.address0    = $urandom;
                bif.write_data0 = $urandom;
            end
            if (!pend1 || served1) begin
                pend1 = ($urandom_range(0, 99) < 55);
                bif.MemRead1  = ($urandom_range(0, 2) == 0);
                bif.MemWrite1 = !bif.MemRead1 && ($urandom_range(0, 1) == 1);
                bif.address1    = $urandom;
                bif.write_data1 = $urandom;
            end
            bif.req0 = pend0;
            bif.req1 = pend1;
            bif.bus_read_data = $urandom;
            @(negedge clk);
            served0 = exp_beat0;
            served1 = exp_beat1;
            next();
        end

        reset = 1'b0;
        clear_masters();
        next();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the memory-mapped bus (data memory, timer, LED, SSD, systick).
- Master 0 is the CPU MEM stage. Master 1 is a DMA/loader engine.
- Registered round-robin grant, optional per-owner burst limit, per-master stall/ready handshake.
- The bus slave side stays single-master. It sees one muxed MemRead/MemWrite/address/write_data set.

Parameters:
MAX_BURST, 8, max consecutive granted cycles for one owner while the other master is requesting (1..2^CNT_WIDTH-1)
CNT_WIDTH, 4, width of the burst counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req0  input  1  master 0 requests the bus; must be held until ready0
MemRead0  input  1  master 0 read strobe
MemWrite0  input  1  master 0 write strobe
address0  input  32  master 0 byte address
write_data0  input  32  master 0 write data
read_data0  output  32  bus_read_data when beat0 active, else 0
ready0  output  1  beat completes this cycle for master 0
stall0  output  1  req0 & ~gnt0 (drives CPU pipeline stall)
req1, MemRead1, MemWrite1, address1, write_data1  input  1/1/1/32/32  master 1 equivalents
read_data1, ready1, stall1  output  32/1/1  master 1 equivalents
gnt0, gnt1  output  1/1  registered grants, mutually exclusive
bus_MemRead  output  1  to bus
bus_MemWrite  output  1  to bus
bus_address  output  32  to bus
bus_write_data  output  32  to bus
bus_read_data  input  32  from bus (combinational read)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, port name reset.
- Reset values: gnt0=gnt1=0, state IDLE, rr_ptr=0 (master 0 preferred next), burst_cnt=0. All outputs are 0 while reset is held.
- States:
  - IDLE: gnt0=gnt1=0.
  - OWN0: gnt0=1.
  - OWN1: gnt1=1.
- Next-state decision uses the current cycle's req0/req1 and is registered at the clock edge.
- From IDLE:
  - only req0 -> OWN0; only req1 -> OWN1; neither -> IDLE.
  - both -> the master selected by rr_ptr.
  - Latency: req rising in cycle N gives grant in N+1.
- From OWNx:
  - owner req high and (other req low, or burst_cnt < MAX_BURST-1) -> stay, burst_cnt++.
  - owner req high, other req high, burst_cnt == MAX_BURST-1 -> switch to other owner, burst_cnt=0.
  - owner req low, other req high -> switch to other owner. No idle bubble.
  - owner req low, other req low -> IDLE.
- rr_ptr: on every grant change into OWNx, rr_ptr <= ~x.
- burst_cnt: resets to 0 on every owner change and in IDLE. Saturates and never wraps. With the other master idle it holds at MAX_BURST-1.
- Beat: beat_x = gnt_x & req_x.
  - bus_* = owner's signals when beat_x, else all zero. No stray writes in IDLE or while the owner has dropped req.
  - ready_x = beat_x, combinational.
  - Each beat is one bus access; writes commit at that clock edge.
- read_data_x = beat_x ? bus_read_data : 0.
- Protocol assumptions: MemRead_x and MemWrite_x both high is illegal. The arbiter forwards both unchanged and does not check.
- Reset asserted mid-burst: next edge forces IDLE. No bus strobe is driven in the reset cycle.
- Invariant: gnt0 & gnt1 never both 1.

Optional Feature:
- Macro: BUS_ARB_BURST_LIMIT_EN.
- Defined: the MAX_BURST preemption rule above applies.
- Undefined: the owner keeps the grant as long as its req stays high, regardless of the other master. The burst_cnt register and MAX_BURST comparison are not synthesised. rr_ptr still governs simultaneous requests from IDLE.

Test Plan:
- Reset then idle, req0=req1=0 for 5 cycles -> gnt0=gnt1=0, bus_MemWrite=0, bus_address=0.
- From IDLE, req0=1 with MemWrite0=1, address0=0x00000010, write_data0=0xDEADBEEF in cycle N -> gnt0=1 at N+1; in N+1 bus_MemWrite=1, bus_address=0x10, ready0=1; stall0=1 in N only.
- Both requests from IDLE after reset -> OWN0 first. After req0 drops, OWN1 next cycle, no bubble. Both re-request from IDLE -> OWN0 (rr_ptr=0 after serving 1).
- BUS_ARB_BURST_LIMIT_EN, MAX_BURST=8, req0 held, req1 raised one cycle after OWN0 entry:
  - gnt0 stays high 8 cycles, then gnt1 high.
  - Exactly 8 ready0 pulses before the switch.
- Same stimulus without the macro -> gnt0 held for all 20 cycles req0 is high; stall1=1 throughout.
- Master 1 reads 0x4000000C while bus_read_data=0x000000A5 -> read_data1=0xA5, read_data0=0. Reset asserted mid-OWN1 -> IDLE next edge, gnt1=0.
